// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide control path.
package multdiv_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_MULT_STEPS = 32;
  localparam int DEF_DIV_STEPS  = 32;
endpackage

// File: rtl/iter_counter.sv
// Iteration up-counter with synchronous clear (priority) and count enable.
module iter_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             en,
  output logic [CNT_W-1:0] value
);
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      value <= '0;
    else if (sclr) value <= '0;
    else if (en)   value <= value + CNT_W'(1);
  end
endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiplier/divider: LOAD, N steps, one-cycle RDY.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MULT_STEPS = DEF_MULT_STEPS,
  parameter int DIV_STEPS  = DEF_DIV_STEPS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  output logic             load,
  output logic             step_en,
  output logic             op_is_div,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_t state, state_nxt;
  logic   start;
  logic   exc;
  logic   last_step;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_step = (iter == (op_is_div ? DIV_LAST : MULT_LAST));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = IDLE;
      LOAD: state_nxt = (op_is_div && divisor_zero) ? DONE : RUN;
      RUN:  state_nxt = last_step ? DONE : RUN;
      DONE: state_nxt = IDLE;
    endcase
    if (start) state_nxt = LOAD;
  end

  // Operation type and div-by-zero flag are captured per operation; a new
  // start discards whatever the aborted one had recorded.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_is_div <= 1'b0;
      exc       <= 1'b0;
    end else if (start) begin
      op_is_div <= ctrl_DIV & ~ctrl_MULT;
      exc       <= 1'b0;
    end else if (state == LOAD) begin
      exc       <= op_is_div & divisor_zero;
    end
  end

  assign load           = (state == LOAD);
  assign step_en        = (state == RUN);
  assign busy           = load | step_en;
  assign data_resultRDY = (state == DONE);
  assign data_exception = data_resultRDY & exc;

  // Clearing on start as well as load makes iter read 0 already in the LOAD
  // cycle, so an aborted op never shows a stale index there.
  iter_counter #(.CNT_W(CNT_W)) u_iter (
    .clk   (clk),
    .clr   (clr),
    .sclr  (start | load),
    .en    (step_en),
    .value (iter)
  );
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: directed scenarios plus random starts against a
// cycles-since-start reference model.
module tb_multdiv_sequencer;
  localparam int CNT_W = 6;
  localparam int MS    = 32;
  localparam int DS    = 32;

  logic clk = 1'b0;
  logic clr, ctrl_MULT, ctrl_DIV, divisor_zero;
  logic load, step_en, op_is_div, busy, data_resultRDY, data_exception;
  logic [CNT_W-1:0] iter;

  multdiv_sequencer #(.CNT_W(CNT_W), .MULT_STEPS(MS), .DIV_STEPS(DS)) dut (
    .clk(clk), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .divisor_zero(divisor_zero), .load(load), .step_en(step_en),
    .op_is_div(op_is_div), .iter(iter), .busy(busy),
    .data_resultRDY(data_resultRDY), .data_exception(data_exception)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  // model: k = cycles since start was sampled (0 = no op in flight)
  int k = 0;
  bit mdiv = 0;
  bit zexc = 0;
  int exp_iter = 0;
  int rdy_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int steps(input bit dv);
    return dv ? DS : MS;
  endfunction

  task automatic model_reset();
    k = 0; mdiv = 0; zexc = 0; exp_iter = 0;
  endtask

  task automatic model_step(input bit m, input bit d, input bit dz);
    int nn;
    nn = steps(mdiv);
    if (m || d) begin
      k = 1; mdiv = d && !m; zexc = 0; exp_iter = 0;
    end else if (k == 1) begin
      if (mdiv && dz) zexc = 1;
      k = 2;
    end else if (k >= 2 && !zexc && k <= nn + 1) begin
      exp_iter++; k++;
    end else if (k != 0) begin
      k = 0;
    end
  endtask

  task automatic check_outputs();
    int nn;
    bit e_load, e_step, e_rdy;
    nn     = steps(mdiv);
    e_load = (k == 1);
    e_step = !zexc && k >= 2 && k <= nn + 1;
    e_rdy  = zexc ? (k == 2) : (k == nn + 2);
    chk("load", 32'(load), 32'(e_load));
    chk("step_en", 32'(step_en), 32'(e_step));
    chk("busy", 32'(busy), 32'(e_load | e_step));
    chk("rdy", 32'(data_resultRDY), 32'(e_rdy));
    chk("exception", 32'(data_exception), 32'(e_rdy && zexc));
    chk("op_is_div", 32'(op_is_div), 32'(mdiv));
    chk("iter", 32'(iter), 32'(exp_iter));
    rdy_seen += int'(data_resultRDY);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outs"}, 32'({load, step_en, op_is_div, busy, data_resultRDY, data_exception}), 32'd0);
    chk({tag, "_iter"}, 32'(iter), 32'd0);
  endtask

  // Drive inputs for one cycle, advance the model at the edge, check at negedge.
  task automatic cycle(input bit m, input bit d, input bit dz);
    ctrl_MULT = m; ctrl_DIV = d; divisor_zero = dz;
    @(posedge clk); #1;
    model_step(m, d, dz);
    ctrl_MULT = 0; ctrl_DIV = 0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit dz);
    for (int i = 0; i < n; i++) cycle(0, 0, dz);
  endtask

  initial begin
    clr = 1'b0; ctrl_MULT = 0; ctrl_DIV = 0; divisor_zero = 0;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
    check_outputs();

    // 1: plain multiply, RDY 34 cycles after start
    rdy_seen = 0;
    cycle(1, 0, 0);
    idle(MS + 3, 0);
    chk("t1_rdy_count", 32'(rdy_seen), 32'd1);

    // 2: divide by zero, RDY right after LOAD
    rdy_seen = 0;
    cycle(0, 1, 0);
    cycle(0, 0, 1);
    chk("t2_exc", 32'(data_exception), 32'd1);
    idle(3, 1);
    chk("t2_rdy_count", 32'(rdy_seen), 32'd1);

    // 3: divide aborted at iter 10 by a multiply
    rdy_seen = 0;
    cycle(0, 1, 0);
    for (int i = 0; i < 40 && !(k >= 2 && exp_iter == 10); i++) cycle(0, 0, 0);
    chk("t3_iter10", 32'(iter), 32'd10);
    cycle(1, 0, 0);
    chk("t3_abort_load", 32'(load), 32'd1);
    idle(MS + 3, 0);
    chk("t3_rdy_count", 32'(rdy_seen), 32'd1);

    // 4: async reset mid-run
    cycle(1, 0, 0);
    for (int i = 0; i < 40 && !(k >= 2 && exp_iter == 17); i++) cycle(0, 0, 0);
    chk("t4_iter17", 32'(iter), 32'd17);
    #2 clr = 1'b0;
    #1 check_zero("t4_async");
    model_reset();
    @(posedge clk); #1 check_zero("t4_held");
    @(negedge clk) clr = 1'b1;
    rdy_seen = 0;
    idle(6, 1);
    chk("t4_quiet_rdy", 32'(rdy_seen), 32'd0);

    // 5: both starts at once -> multiply; divisor_zero must not matter
    rdy_seen = 0;
    cycle(1, 1, 1);
    chk("t5_op", 32'(op_is_div), 32'd0);
    idle(MS + 3, 1);
    chk("t5_rdy_count", 32'(rdy_seen), 32'd1);

    // 6: new start during DONE
    rdy_seen = 0;
    cycle(1, 0, 0);
    idle(MS + 1, 0);
    chk("t6_done_rdy", 32'(data_resultRDY), 32'd1);
    cycle(0, 1, 0);
    chk("t6_load_next", 32'(load), 32'd1);
    idle(DS + 3, 0);
    chk("t6_rdy_count", 32'(rdy_seen), 32'd2);

    // random starts, opcodes and divisor_zero
    for (int i = 0; i < 4000; i++) begin
      bit m, d;
      m = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 39) == 0);
      cycle(m, d, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
